// File: rtl/writeback_regfile_if.sv
// -----------------------------------------------------------------------------
// writeback_regfile_if
// Bundle between the memory stage / decode stage and the writeback register
// file of the SEQ Y86-64 core.
//   Retire side : instr_valid, icode, rA, rB, cnd, valE, valM,
//                 imem_error, dmem_error            (into the register file)
//   Read side   : srcA, srcB, dbg_addr              (into the register file)
//                 valA, valB, dbg_data              (out of the register file)
//   Status      : stat, retired                     (out of the register file)
// The master modport is the pipeline/decode side, the slave modport is the
// register file itself.
// -----------------------------------------------------------------------------
interface writeback_regfile_if;
    logic        instr_valid;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        imem_error;
    logic        dmem_error;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic [2:0]  stat;
    logic [63:0] retired;

    modport master (
        output instr_valid, icode, rA, rB, cnd, valE, valM,
        output imem_error, dmem_error,
        output srcA, srcB, dbg_addr,
        input  valA, valB, dbg_data, stat, retired
    );

    modport slave (
        input  instr_valid, icode, rA, rB, cnd, valE, valM,
        input  imem_error, dmem_error,
        input  srcA, srcB, dbg_addr,
        output valA, valB, dbg_data, stat, retired
    );
endinterface

// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
// Writeback stage and 15-entry x 64-bit architectural register file of the
// SEQ Y86-64 processor.  One instruction retires per rising clock edge:
// valE is written to dstE and valM to dstM (valM wins when both target the
// same register, e.g. popq %rsp).  A sticky processor status and a counter
// of successfully retired instructions are also kept here.
//
// Ports
//   clk  : system clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset (clears registers, stat=AOK,
//          retired=0)
//   wb   : writeback_regfile_if.slave
//          retire inputs  instr_valid, icode, rA, rB, cnd, valE, valM,
//                         imem_error, dmem_error
//          read inputs    srcA, srcB, dbg_addr (0xF reads as zero)
//          outputs        valA, valB, dbg_data (combinational from state),
//                         stat (1=AOK 2=HLT 3=ADR 4=INS), retired
// -----------------------------------------------------------------------------
module writeback_regfile (
    input  logic               clk,
    input  logic               rst,
    writeback_regfile_if.slave wb
);

    // Architectural status codes; values are visible on the stat output.
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam int NUM_REGS = 15;

    // Status a valid instruction would produce, highest priority first:
    // address faults, then illegal opcodes, then halt.
    function automatic stat_e classify_status(
        input logic       imem_err,
        input logic       dmem_err,
        input logic [3:0] icode
    );
        stat_e s;
        if (imem_err || dmem_err) begin
            s = STAT_ADR;
        end else if (icode > I_POPQ) begin
            s = STAT_INS;
        end else if (icode == I_HALT) begin
            s = STAT_HLT;
        end else begin
            s = STAT_AOK;
        end
        return s;
    endfunction

    // Register 0xF is the "no register" specifier and always reads zero.
    function automatic logic [63:0] read_reg(
        input logic [63:0] regs [0:NUM_REGS-1],
        input logic [3:0]  addr
    );
        logic [63:0] data;
        if (addr == REG_NONE) begin
            data = 64'd0;
        end else begin
            data = regs[addr];
        end
        return data;
    endfunction

    logic [63:0] regs_q    [0:NUM_REGS-1];
    logic [63:0] regs_d    [0:NUM_REGS-1];
    stat_e       stat_q;
    stat_e       stat_d;
    logic [63:0] retired_q;
    logic [63:0] retired_d;

    logic [3:0]  dst_e_s;
    logic [3:0]  dst_m_s;
    stat_e       next_stat_s;
    logic        commit_s;

    // Destination decode for the completing instruction.
    always_comb begin
        dst_e_s = REG_NONE;
        dst_m_s = REG_NONE;
        case (wb.icode)
            I_CMOVXX: begin
                // A failed conditional move retires but writes nothing.
                if (wb.cnd) begin
                    dst_e_s = wb.rB;
                end else begin
                    dst_e_s = REG_NONE;
                end
            end
            I_IRMOVQ, I_OPQ: begin
                dst_e_s = wb.rB;
            end
            I_MRMOVQ: begin
                dst_m_s = wb.rA;
            end
            I_CALL, I_RET, I_PUSHQ: begin
                dst_e_s = REG_RSP;
            end
            I_POPQ: begin
                dst_e_s = REG_RSP;
                dst_m_s = wb.rA;
            end
            default: begin
                dst_e_s = REG_NONE;
                dst_m_s = REG_NONE;
            end
        endcase
    end

    // Status classification of the instruction on the bus.
    always_comb begin
        next_stat_s = classify_status(wb.imem_error, wb.dmem_error, wb.icode);
    end

    // Status FSM next state and commit qualifier: only AOK can move, and a
    // fault/halt moves the status instead of committing.
    always_comb begin
        stat_d   = stat_q;
        commit_s = 1'b0;
        case (stat_q)
            STAT_AOK: begin
                if (wb.instr_valid) begin
                    if (next_stat_s != STAT_AOK) begin
                        stat_d   = next_stat_s;
                        commit_s = 1'b0;
                    end else begin
                        stat_d   = STAT_AOK;
                        commit_s = 1'b1;
                    end
                end else begin
                    stat_d   = STAT_AOK;
                    commit_s = 1'b0;
                end
            end
            STAT_HLT, STAT_ADR, STAT_INS: begin
                // Terminal states absorb everything until reset.
                stat_d   = stat_q;
                commit_s = 1'b0;
            end
            default: begin
                // An unencodable status is treated as an address fault so the
                // core stops rather than retiring from corrupted state.
                stat_d   = STAT_ADR;
                commit_s = 1'b0;
            end
        endcase
    end

    // Register file next state; the M port is checked first so it wins over
    // the E port when both name the same register.  0xF never matches an
    // entry, which discards writes to "no register".
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit_s && (dst_m_s == 4'(i))) begin
                regs_d[i] = wb.valM;
            end else if (commit_s && (dst_e_s == 4'(i))) begin
                regs_d[i] = wb.valE;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Retired-instruction counter next state (wraps naturally at 2^64).
    always_comb begin
        if (commit_s) begin
            retired_d = retired_q + 64'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 64'd0;
            end
            stat_q    <= STAT_AOK;
            retired_q <= 64'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    // Read ports see stored state only, so a same-cycle write is not
    // forwarded; the new value appears right after the committing edge.
    assign wb.valA     = read_reg(regs_q, wb.srcA);
    assign wb.valB     = read_reg(regs_q, wb.srcB);
    assign wb.dbg_data = read_reg(regs_q, wb.dbg_addr);
    assign wb.stat     = stat_q;
    assign wb.retired  = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_writeback_regfile
// Scoreboard bench for writeback_regfile.  The driver issues instructions and
// pushes the expected read-port/status/counter values computed by an
// architectural model (array of 16 registers, status code, counter) into a
// queue; an independent monitor pops each entry and compares it against the
// DUT outputs.
// -----------------------------------------------------------------------------
module tb_writeback_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    writeback_regfile_if wb_if ();

    writeback_regfile dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] d;
        logic [2:0]  s;
        logic [63:0] r;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks   = 0;
    int   failures = 0;

    // Architectural model: entry 15 is never written, so it always reads 0.
    logic [63:0] m_regs [0:15];
    logic [2:0]  m_stat;
    logic [63:0] m_ret;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
        m_stat = 3'd1;
        m_ret  = 64'd0;
    endfunction

    // Effect of one clock edge on the architectural state.
    function automatic void model_step();
        logic [2:0] ns;
        logic [3:0] de;
        logic [3:0] dm;
        if (!wb_if.instr_valid) return;
        if (m_stat != 3'd1) return;
        if (wb_if.imem_error || wb_if.dmem_error) ns = 3'd3;
        else if (wb_if.icode >= 4'hC)             ns = 3'd4;
        else if (wb_if.icode == 4'h0)             ns = 3'd2;
        else                                      ns = 3'd1;
        if (ns != 3'd1) begin
            m_stat = ns;
            return;
        end
        de = 4'hF;
        dm = 4'hF;
        case (wb_if.icode)
            4'h2:             if (wb_if.cnd) de = wb_if.rB;
            4'h3, 4'h6:       de = wb_if.rB;
            4'h5:             dm = wb_if.rA;
            4'h8, 4'h9, 4'hA: de = 4'h4;
            4'hB: begin
                de = 4'h4;
                dm = wb_if.rA;
            end
            default: ;
        endcase
        if (de != 4'hF) m_regs[de] = wb_if.valE;
        if (dm != 4'hF) m_regs[dm] = wb_if.valM;
        m_ret = m_ret + 64'd1;
    endfunction

    function automatic void push_exp(input string nm);
        exp_t e;
        e.name = nm;
        e.a    = m_regs[wb_if.srcA];
        e.b    = m_regs[wb_if.srcB];
        e.d    = m_regs[wb_if.dbg_addr];
        e.s    = m_stat;
        e.r    = m_ret;
        exp_q.push_back(e);
        -> sample_ev;
    endfunction

    function automatic void cmp(input string nm, input string field,
                                input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s.%s got=%h expected=%h", nm, field, act, expv);
        end
    endfunction

    // Monitor: compares DUT outputs whenever the driver announces a sample.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "valA",     wb_if.valA,     e.a);
                cmp(e.name, "valB",     wb_if.valB,     e.b);
                cmp(e.name, "dbg_data", wb_if.dbg_data, e.d);
                cmp(e.name, "stat",     {61'd0, wb_if.stat}, {61'd0, e.s});
                cmp(e.name, "retired",  wb_if.retired,  e.r);
            end
        end
    end

    task automatic set_reads(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] dd);
        wb_if.srcA     = sa;
        wb_if.srcB     = sb;
        wb_if.dbg_addr = dd;
    endtask

    // One instruction: checks old values before the edge, new values after.
    task automatic instr(input string nm, input logic v, input logic [3:0] ic,
                         input logic [3:0] ra, input logic [3:0] rb, input logic c,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic ie, input logic de);
        @(negedge clk);
        wb_if.instr_valid = v;
        wb_if.icode       = ic;
        wb_if.rA          = ra;
        wb_if.rB          = rb;
        wb_if.cnd         = c;
        wb_if.valE        = ve;
        wb_if.valM        = vm;
        wb_if.imem_error  = ie;
        wb_if.dmem_error  = de;
        #2;
        push_exp({nm, "_pre"});
        @(posedge clk);
        model_step();
        #1;
        push_exp({nm, "_post"});
        #1;
    endtask

    // Reset held across an edge with garbage valid inputs, then released.
    task automatic do_reset(input string nm);
        @(negedge clk);
        wb_if.instr_valid = 1'b1;
        wb_if.icode       = 4'($urandom_range(1, 11));
        wb_if.rA          = 4'($urandom_range(0, 14));
        wb_if.rB          = 4'($urandom_range(0, 14));
        wb_if.cnd         = 1'b1;
        wb_if.valE        = {$urandom, $urandom};
        wb_if.valM        = {$urandom, $urandom};
        wb_if.imem_error  = 1'($urandom_range(0, 1));
        wb_if.dmem_error  = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        push_exp({nm, "_on"});
        @(posedge clk);
        #1;
        push_exp({nm, "_held"});
        @(negedge clk);
        wb_if.instr_valid = 1'b0;
        rst = 1'b0;
        #1;
        push_exp({nm, "_rel"});
        @(posedge clk);
        #1;
        push_exp({nm, "_edge"});
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        logic [3:0] ic;
        logic [3:0] code_list [0:10];
        code_list[0] = 4'h1; code_list[1] = 4'h2; code_list[2]  = 4'h3;
        code_list[3] = 4'h4; code_list[4] = 4'h5; code_list[5]  = 4'h6;
        code_list[6] = 4'h7; code_list[7] = 4'h8; code_list[8]  = 4'h9;
        code_list[9] = 4'hA; code_list[10] = 4'hB;

        wb_if.instr_valid = 1'b0;
        wb_if.icode = 4'h0; wb_if.rA = 4'hF; wb_if.rB = 4'hF; wb_if.cnd = 1'b0;
        wb_if.valE = 64'd0; wb_if.valM = 64'd0;
        wb_if.imem_error = 1'b0; wb_if.dmem_error = 1'b0;
        set_reads(4'h2, 4'h4, 4'h5);
        model_reset();

        // Reset and basic writes
        do_reset("reset");
        set_reads(4'h2, 4'hF, 4'h2);
        instr("irmovq", 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b0, 1'b0);
        set_reads(4'h4, 4'h2, 4'h4);
        instr("popq_rsp", 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABCD, 1'b0, 1'b0);
        set_reads(4'h5, 4'h4, 4'h5);
        instr("mrmovq", 1'b1, 4'h5, 4'h5, 4'h2, 1'b0, 64'h55, 64'h7, 1'b0, 1'b0);
        set_reads(4'h3, 4'h5, 4'h3);
        instr("cmov_nt", 1'b1, 4'h2, 4'h1, 4'h3, 1'b0, 64'h9, 64'h0, 1'b0, 1'b0);
        instr("cmov_t", 1'b1, 4'h2, 4'h1, 4'h3, 1'b1, 64'h9, 64'h0, 1'b0, 1'b0);
        set_reads(4'h4, 4'h3, 4'hF);
        instr("pushq", 1'b1, 4'hA, 4'h3, 4'hF, 1'b0, 64'hF0, 64'h0, 1'b0, 1'b0);
        instr("write_none", 1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'hDEAD, 64'h0, 1'b0, 1'b0);
        set_reads(4'h1, 4'h2, 4'h1);
        instr("bubble", 1'b0, 4'h3, 4'hF, 4'h1, 1'b0, 64'h77, 64'h0, 1'b0, 1'b0);

        // Halt and stickiness
        instr("halt", 1'b1, 4'h0, 4'hF, 4'h1, 1'b0, 64'h5, 64'h0, 1'b0, 1'b0);
        instr("after_halt", 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h66, 64'h0, 1'b0, 1'b0);

        // Address fault on OPq, illegal opcode
        do_reset("reset2");
        set_reads(4'h6, 4'h2, 4'h6);
        instr("opq_ok", 1'b1, 4'h6, 4'h2, 4'h6, 1'b0, 64'h11, 64'h0, 1'b0, 1'b0);
        instr("opq_dmem", 1'b1, 4'h6, 4'h2, 4'h6, 1'b0, 64'h22, 64'h0, 1'b0, 1'b1);
        instr("after_adr", 1'b1, 4'hC, 4'h2, 4'h6, 1'b0, 64'h33, 64'h0, 1'b0, 1'b0);
        do_reset("reset3");
        instr("ins", 1'b1, 4'hC, 4'h2, 4'h6, 1'b0, 64'h44, 64'h0, 1'b0, 1'b0);
        do_reset("reset4");
        instr("imem_halt", 1'b1, 4'h0, 4'h2, 4'h6, 1'b0, 64'h44, 64'h0, 1'b1, 1'b0);

        // Mid-cycle asynchronous reset after several writes
        do_reset("reset5");
        set_reads(4'h2, 4'h7, 4'h8);
        instr("w2", 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'hA2, 64'h0, 1'b0, 1'b0);
        instr("w7", 1'b1, 4'h3, 4'hF, 4'h7, 1'b0, 64'hA7, 64'h0, 1'b0, 1'b0);
        instr("w8", 1'b1, 4'h6, 4'hF, 4'h8, 1'b0, 64'hA8, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        wb_if.instr_valid = 1'b1;
        wb_if.icode = 4'h3; wb_if.rB = 4'h2; wb_if.valE = 64'hBAD;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_exp("mid_rst");
        @(posedge clk);
        #1;
        push_exp("mid_rst_edge");
        @(negedge clk);
        wb_if.instr_valid = 1'b0;
        rst = 1'b0;
        #1;

        // Randomized segments, each ending a few cycles after a fault
        for (int seg = 0; seg < 4; seg++) begin
            do_reset("rnd_reset");
            extra = 0;
            for (int n = 0; n < 60; n++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 2)      ic = 4'h0;
                else if (r < 4) ic = 4'($urandom_range(12, 15));
                else            ic = code_list[$urandom_range(0, 10)];
                set_reads(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)));
                instr("rnd", 1'($urandom_range(0, 9) != 0), ic,
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                      1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) == 0));
                if (m_stat != 3'd1) extra++;
                if (extra > 3) break;
            end
        end

        #20;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
